// File: rtl/seg_serial_ctrl_pkg.sv
// Shared constants for the serial 7-segment chain sequencer: hex glyph codes,
// FSM encoding and the fixed frame length.
package seg_serial_ctrl_pkg;

  localparam int SEG_NBITS = 64;

  // Active-low {dp,g,f,e,d,c,b,a}; bit 7 is replaced by the decimal point.
  localparam logic [7:0] SEG7_0 = 8'hC0;
  localparam logic [7:0] SEG7_1 = 8'hF9;
  localparam logic [7:0] SEG7_2 = 8'hA4;
  localparam logic [7:0] SEG7_3 = 8'hB0;
  localparam logic [7:0] SEG7_4 = 8'h99;
  localparam logic [7:0] SEG7_5 = 8'h92;
  localparam logic [7:0] SEG7_6 = 8'h82;
  localparam logic [7:0] SEG7_7 = 8'hF8;
  localparam logic [7:0] SEG7_8 = 8'h80;
  localparam logic [7:0] SEG7_9 = 8'h90;
  localparam logic [7:0] SEG7_A = 8'h88;
  localparam logic [7:0] SEG7_B = 8'h83;
  localparam logic [7:0] SEG7_C = 8'hC6;
  localparam logic [7:0] SEG7_D = 8'hA1;
  localparam logic [7:0] SEG7_E = 8'h86;
  localparam logic [7:0] SEG7_F = 8'h8E;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT_L = 3'd2,
    ST_SHIFT_H = 3'd3,
    ST_LATCH   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic logic [7:0] seg_byte(input logic [6:0] seg, input logic dp, input logic blank);
    return blank ? 8'hFF : {~dp, seg};
  endfunction

endpackage

// File: rtl/seg_serial_ctrl_if.sv
// Request/status and chain-pin bundle between the display mux and the sequencer.
interface seg_serial_ctrl_if;
  logic        start;
  logic [31:0] data;
  logic [7:0]  point;
  logic [7:0]  les;
  logic        busy;
  logic        done;
  logic        SEGLED_CLK;
  logic        SEGLED_DO;
  logic        SEGLED_PEN;
  logic        SEGLED_CLR;

  modport master (
    output start, data, point, les,
    input  busy, done, SEGLED_CLK, SEGLED_DO, SEGLED_PEN, SEGLED_CLR
  );

  modport slave (
    input  start, data, point, les,
    output busy, done, SEGLED_CLK, SEGLED_DO, SEGLED_PEN, SEGLED_CLR
  );
endinterface

// File: rtl/seg_serial_ctrl_hex7seg.sv
// Combinational hex nibble to active-low 7-segment code {g,f,e,d,c,b,a}.
module hex7seg
  import seg_serial_ctrl_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_nib)
      4'h0: o_seg = SEG7_0[6:0];
      4'h1: o_seg = SEG7_1[6:0];
      4'h2: o_seg = SEG7_2[6:0];
      4'h3: o_seg = SEG7_3[6:0];
      4'h4: o_seg = SEG7_4[6:0];
      4'h5: o_seg = SEG7_5[6:0];
      4'h6: o_seg = SEG7_6[6:0];
      4'h7: o_seg = SEG7_7[6:0];
      4'h8: o_seg = SEG7_8[6:0];
      4'h9: o_seg = SEG7_9[6:0];
      4'hA: o_seg = SEG7_A[6:0];
      4'hB: o_seg = SEG7_B[6:0];
      4'hC: o_seg = SEG7_C[6:0];
      4'hD: o_seg = SEG7_D[6:0];
      4'hE: o_seg = SEG7_E[6:0];
      4'hF: o_seg = SEG7_F[6:0];
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_serial_ctrl.sv
// Frame sequencer for the serial 7-segment chain: captures a display word, shifts
// 64 bits MSB-first with a generated shift clock, then latches the frame.
module seg_serial_ctrl
  import seg_serial_ctrl_pkg::*;
#(
  parameter int HALF  = 4,
  parameter int NBITS = SEG_NBITS
) (
  input  logic              clk,
  input  logic              RSTN,
  seg_serial_ctrl_if.slave  bus
);

  localparam int             PW       = $clog2(HALF + 1);
  localparam logic [PW-1:0]  PH_LAST  = PW'(HALF - 1);
  localparam logic [5:0]     BIT_LAST = 6'(NBITS - 1);

  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_phase;
  logic [5:0]         r_bit;
  logic [NBITS-1:0]   r_shift;
  logic [NBITS-1:0]   w_frame;
  logic [6:0]         w_seg [8];
  logic               w_ph_end, w_last_bit, w_advance;
  logic               r_busy, r_done, r_clk, r_do, r_pen, r_clr;
  logic               w_busy_nxt, w_done_nxt, w_clk_nxt, w_do_nxt, w_pen_nxt;

  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    hex7seg u_hex (.i_nib(bus.data[4*gi +: 4]), .o_seg(w_seg[gi]));
    assign w_frame[8*gi +: 8] = seg_byte(w_seg[gi], bus.point[gi], bus.les[gi]);
  end

  assign w_ph_end   = (r_phase == PH_LAST);
  assign w_last_bit = (r_bit == BIT_LAST);
  assign w_advance  = (r_state == ST_SHIFT_H) && w_ph_end && !w_last_bit;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_clk   <= 1'b0;
      r_do    <= 1'b0;
      r_pen   <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)
        r_phase <= '0;
      else if (r_state inside {ST_SHIFT_L, ST_SHIFT_H, ST_LATCH})
        r_phase <= r_phase + PW'(1);
      if (r_state == ST_LOAD)
        r_bit <= '0;
      else if (w_advance)
        r_bit <= r_bit + 6'd1;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_clk  <= w_clk_nxt;
      r_do   <= w_do_nxt;
      r_pen  <= w_pen_nxt;
      r_clr  <= 1'b1;
    end
  end

  // Frame data is not reset: it is always reloaded at accept before use.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && bus.start)
      r_shift <= w_frame;
    else if (w_advance)
      r_shift <= {r_shift[NBITS-2:0], 1'b0};
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (bus.start) w_state_nxt = ST_LOAD;
      ST_LOAD:    w_state_nxt = ST_SHIFT_L;
      ST_SHIFT_L: if (w_ph_end) w_state_nxt = ST_SHIFT_H;
      ST_SHIFT_H: if (w_ph_end) w_state_nxt = w_last_bit ? ST_LATCH : ST_SHIFT_L;
      ST_LATCH:   if (w_ph_end) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state requires; DO only
  // moves on the edge that drops the shift clock.
  always_comb begin
    w_busy_nxt = w_state_nxt inside {ST_LOAD, ST_SHIFT_L, ST_SHIFT_H, ST_LATCH};
    w_done_nxt = (w_state_nxt == ST_DONE);
    w_clk_nxt  = (w_state_nxt == ST_SHIFT_H);
    w_pen_nxt  = !(w_state_nxt inside {ST_SHIFT_L, ST_SHIFT_H});
    w_do_nxt   = r_do;
    if (r_state == ST_LOAD)
      w_do_nxt = r_shift[NBITS-1];
    else if (w_advance)
      w_do_nxt = r_shift[NBITS-2];
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.SEGLED_CLK = r_clk;
  assign bus.SEGLED_DO  = r_do;
  assign bus.SEGLED_PEN = r_pen;
  assign bus.SEGLED_CLR = r_clr;

endmodule
